// File: rtl/fs_vid_pkg.sv
// fs_vid_pkg: shared FSM state encoding and FIFO entry field offsets for fs_vid_to_axis
package fs_vid_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, WAIT_SOF, STREAM, DROP} state_t;
  localparam int SOF_BIT = 0;
  localparam int EOL_BIT = 1;
  localparam int DATA_LSB = 2;
endpackage

// File: rtl/fs_sync_fifo.sv
// fs_sync_fifo: single-clock first-word-fall-through FIFO
//   wr_en/din : push (ignored when full unless a pop happens the same cycle)
//   rd_en     : pop (ignored when empty); dout shows the head entry whenever !empty
//   full/empty: occupancy flags
module fs_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0] cnt;
  logic wr, rd;
  assign empty = cnt == '0;
  assign full = cnt[DEPTH_LOG2];
  assign rd = rd_en && !empty;
  assign wr = wr_en && (!full || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(wr);
      rp <= rp + DEPTH_LOG2'(rd);
      cnt <= cnt + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/fs_vid_to_axis.sv
// fs_vid_to_axis: CMOS video timing bus to AXI4-Stream with frame measurement and overflow resync
//   clk, resetn                      : pixel clock, async active-low reset
//   vid_active_video/vid_data/vblank : capture-stage pixel bus (vblank level C_FRAME_LEVEL = frame valid)
//   m_axis_*                         : AXI4-Stream master, tuser = start of frame, tlast = end of line
//   frame_width/height/count         : geometry of the last good frame and good-frame count
//   overflow                         : sticky FIFO overflow flag
module fs_vid_to_axis #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_FIFO_DEPTH_LOG2 = 5,
  parameter int C_SIZE_WIDTH = 12,
  parameter int C_FRAME_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    vid_active_video,
  input  logic [C_DATA_WIDTH-1:0] vid_data,
  input  logic                    vid_vblank,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic [C_SIZE_WIDTH-1:0] frame_width,
  output logic [C_SIZE_WIDTH-1:0] frame_height,
  output logic [15:0]             frame_count,
  output logic                    overflow
);
  import fs_vid_pkg::*;
  localparam int EW = C_DATA_WIDTH + 2;
  state_t state;
  logic act_r, vb_r, in_v, fv, fv_q, act_q, fstart, fend, fall, pix, push, ovf;
  logic hold_v, hold_sof, sof_pend, full, empty;
  logic [C_DATA_WIDTH-1:0] data_r, hold_d;
  logic [EW-1:0] din, dout;
  logic [C_SIZE_WIDTH-1:0] pix_cnt, line_cnt;
  // in_v keeps the reset value of the input register from looking like a frame gap
  assign fv = vb_r == 1'(C_FRAME_LEVEL);
  assign fstart = fv && !fv_q;
  assign fend = !fv && fv_q;
  assign fall = act_q && !act_r;
  assign pix = act_r && state == STREAM && !fend;
  // pix and fall/fend are mutually exclusive, so a push without a new pixel closes the line
  assign push = hold_v && (pix || fall || fend);
  assign ovf = push && full && !m_axis_tready;
  always_comb begin
    din = '0;
    din[SOF_BIT] = hold_sof;
    din[EOL_BIT] = !pix;
    din[EW-1:DATA_LSB] = hold_d;
  end
  fs_sync_fifo #(.WIDTH(EW), .DEPTH_LOG2(C_FIFO_DEPTH_LOG2)) u_fifo (
    .clk(clk), .resetn(resetn), .wr_en(push && !ovf), .din(din), .full(full),
    .rd_en(m_axis_tready), .dout(dout), .empty(empty)
  );
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata = empty ? '0 : dout[EW-1:DATA_LSB];
  assign m_axis_tuser = !empty && dout[SOF_BIT];
  assign m_axis_tlast = !empty && dout[EOL_BIT];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= WAIT_IDLE;
      act_r <= 1'b0;
      vb_r <= 1'b0;
      data_r <= '0;
      in_v <= 1'b0;
      fv_q <= 1'b0;
      act_q <= 1'b0;
      hold_v <= 1'b0;
      hold_sof <= 1'b0;
      hold_d <= '0;
      sof_pend <= 1'b0;
      pix_cnt <= '0;
      line_cnt <= '0;
      frame_width <= '0;
      frame_height <= '0;
      frame_count <= '0;
      overflow <= 1'b0;
    end else begin
      act_r <= vid_active_video;
      vb_r <= vid_vblank;
      data_r <= vid_data;
      in_v <= 1'b1;
      fv_q <= fv;
      act_q <= act_r;
      if (ovf) begin
        overflow <= 1'b1;
        hold_v <= 1'b0;
        state <= fend ? WAIT_SOF : DROP;
      end else begin
        if (pix) begin
          hold_v <= 1'b1;
          hold_d <= data_r;
          hold_sof <= sof_pend;
          sof_pend <= 1'b0;
          pix_cnt <= !act_q ? C_SIZE_WIDTH'(1) : (&pix_cnt ? pix_cnt : pix_cnt + 1'b1);
        end else if (push) hold_v <= 1'b0;
        if (fall && state == STREAM) line_cnt <= line_cnt + 1'b1;
        case (state)
          WAIT_IDLE: if (in_v && !fv) state <= WAIT_SOF;
          WAIT_SOF: if (fstart) begin
            state <= STREAM;
            sof_pend <= 1'b1;
            line_cnt <= '0;
          end
          STREAM: if (fend) begin
            state <= WAIT_SOF;
            frame_width <= pix_cnt;
            frame_height <= line_cnt + C_SIZE_WIDTH'(fall);
            frame_count <= frame_count + 16'd1;
          end
          default: if (fend) state <= WAIT_SOF;
        endcase
      end
    end
endmodule

// File: tb/tb_fs_vid_to_axis.sv
// tb_fs_vid_to_axis: table-driven and randomized check of fs_vid_to_axis against a frame-level model
module tb_fs_vid_to_axis;
  logic clk = 0, resetn = 0, vid_active_video = 0, vid_vblank = 0, m_axis_tready = 0;
  logic [7:0] vid_data = 0;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow;
  logic [7:0] m_axis_tdata;
  logic [11:0] frame_width, frame_height;
  logic [15:0] frame_count;
  fs_vid_to_axis dut (
    .clk(clk), .resetn(resetn), .vid_active_video(vid_active_video), .vid_data(vid_data),
    .vid_vblank(vid_vblank), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .frame_width(frame_width), .frame_height(frame_height), .frame_count(frame_count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    int nl;
    int ppl;
    int gap;
    int rdy;
    bit fvlast;
    int w;
    int h;
  } vec_t;
  int n_cmp = 0, n_bad = 0, rdy_pct = 100, exp_cnt = 0;
  logic [31:0] exp_q[$], cap_q[$];
  bit stall_prev = 0;
  logic [9:0] stall_val;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    m_axis_tready = rdy_pct >= 100 ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
  end
  always @(negedge clk) begin
    if (stall_prev) chk("tdata_stable", {21'd0, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {21'd0, 1'b1, stall_val});
    if (m_axis_tvalid && m_axis_tready) cap_q.push_back({22'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast});
    stall_prev = m_axis_tvalid && !m_axis_tready;
    stall_val = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
  end
  task automatic cyc(input bit a, input bit f, input logic [7:0] d);
    @(posedge clk);
    #1;
    vid_active_video = a;
    vid_vblank = f;
    vid_data = d;
  endtask
  // expected beats: every pixel in order, tuser on the frame's first kept pixel, tlast on each line's last
  task automatic send_frame(input int lens[$], input int gap, input bit fvlast, input int keep);
    int k = 0;
    logic [7:0] d;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    for (int l = 0; l < lens.size(); l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        d = 8'($urandom);
        cyc(1, 1, d);
        if (keep < 0 || k < keep) exp_q.push_back({22'd0, d, 1'(k == 0), 1'(p == lens[l] - 1)});
        k++;
      end
      if (!(fvlast && l == lens.size() - 1)) repeat (gap) cyc(0, 1, 0);
    end
    repeat (5) cyc(0, 0, 0);
  endtask
  task automatic drain();
    int t = 0;
    while (m_axis_tvalid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_bound", {31'd0, 1'(t < 3000)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask
  task automatic check_beats(input string nm);
    chk({nm, "_nbeats"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) chk({nm, "_beat"}, cap_q[i], exp_q[i]);
    cap_q = {};
    exp_q = {};
  endtask
  task automatic check_frame(input string nm, input int w, input int h);
    drain();
    check_beats(nm);
    chk({nm, "_width"}, frame_width, w);
    chk({nm, "_height"}, frame_height, h);
    chk({nm, "_count"}, frame_count, exp_cnt);
  endtask
  initial begin
    vec_t tbl[4];
    int lens[$];
    tbl[0] = '{3, 4, 1, 100, 0, 4, 3};
    tbl[1] = '{4, 16, 16, 50, 0, 16, 4};
    tbl[2] = '{5, 1, 1, 100, 1, 1, 5};
    tbl[3] = '{2, 7, 2, 30, 1, 7, 2};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_width", frame_width, 0);
    chk("rst_height", frame_height, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 resetn = 1;
    repeat (3) cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rdy_pct = tbl[i].rdy;
      lens = {};
      repeat (tbl[i].nl) lens.push_back(tbl[i].ppl);
      send_frame(lens, tbl[i].gap, tbl[i].fvlast, -1);
      rdy_pct = 100;
      exp_cnt++;
      check_frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].h);
    end
    cyc(1, 1, 8'h11);
    #1 resetn = 0;
    for (int i = 0; i < 3; i++) cyc(1'(i % 2), 1, 8'(i));
    @(negedge clk);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_count", frame_count, 0);
    @(posedge clk);
    #1 resetn = 1;
    for (int i = 0; i < 10; i++) cyc(1'(i % 3 != 2), 1, 8'($urandom));
    repeat (4) cyc(0, 0, 0);
    exp_cnt = 1;
    send_frame('{5, 5, 5}, 2, 0, -1);
    check_frame("midrst", 5, 3);
    rdy_pct = 0;
    repeat (2) @(posedge clk);
    send_frame('{40}, 1, 0, 32);
    chk("ovf_flag", overflow, 1);
    rdy_pct = 100;
    check_frame("ovf", 5, 3);
    exp_cnt++;
    send_frame('{6, 6}, 1, 0, -1);
    check_frame("post_ovf", 6, 2);
    chk("ovf_sticky", overflow, 1);
    for (int r = 0; r < 6; r++) begin
      lens = {};
      repeat ($urandom_range(1, 3)) lens.push_back($urandom_range(1, 12));
      rdy_pct = $urandom_range(50, 100);
      send_frame(lens, $urandom_range(1, 3), 1'($urandom_range(0, 1)), -1);
      rdy_pct = 100;
      exp_cnt++;
      check_frame("rand", lens[lens.size() - 1], lens.size());
    end
    @(negedge clk);
    force dut.frame_count = 16'hFFFE;
    #2 release dut.frame_count;
    exp_cnt = 16'hFFFF;
    send_frame('{3}, 1, 0, -1);
    check_frame("wrap_ffff", 3, 1);
    exp_cnt = 0;
    send_frame('{2, 2}, 1, 0, -1);
    check_frame("wrap_zero", 2, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
